// File: rtl/sobel_edge_3x3.sv
// Sobel edge detector on a 3x3 window stream.
// Three-stage pipeline: partial sums, absolute gradients, magnitude/threshold plus framing.
// No stall and no backpressure. One pixel per clock with a fixed latency of 3.
module sobel_edge_3x3 #(
  parameter logic [11:0] H_DISP   = 12'd640,
  parameter logic [11:0] V_DISP   = 12'd480,
  parameter logic        OUT_MODE = 1'b0     // 0: binary against thresh, 1: saturated magnitude
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        matrix_vld,
  input  logic [7:0]  matrix_11,
  input  logic [7:0]  matrix_12,
  input  logic [7:0]  matrix_13,
  input  logic [7:0]  matrix_21,
  input  logic [7:0]  matrix_22,
  input  logic [7:0]  matrix_23,
  input  logic [7:0]  matrix_31,
  input  logic [7:0]  matrix_32,
  input  logic [7:0]  matrix_33,
  input  logic [10:0] thresh,
  output logic        dout_vld,
  output logic [7:0]  dout,
  output logic        dout_sof,
  output logic        dout_eol,
  output logic        dout_eof
);

  // Valid pipe: bit 2 is the output valid.
  logic [2:0]  r_vld;

  // Stage 1 partial sums (max 1020 each).
  logic [9:0]  w_px, w_nx, w_py, w_ny;
  logic [9:0]  r_px, r_nx, r_py, r_ny;

  // Stage 2 absolute gradients.
  logic [9:0]  w_gx, w_gy;
  logic [9:0]  r_gx, r_gy;

  // Stage 3 magnitude, output pixel and framing.
  logic [10:0] w_g;
  logic [7:0]  w_pix;
  logic [7:0]  r_dout;
  logic        r_sof, r_eol, r_eof;
  logic [11:0] r_col, r_row;
  logic        w_col_last, w_row_last;

  // matrix_22 carries no weight in either kernel.
  logic        w_unused;
  assign w_unused = ^matrix_22;

  assign w_px = {2'b00, matrix_13} + {1'b0, matrix_23, 1'b0} + {2'b00, matrix_33};
  assign w_nx = {2'b00, matrix_11} + {1'b0, matrix_21, 1'b0} + {2'b00, matrix_31};
  assign w_py = {2'b00, matrix_31} + {1'b0, matrix_32, 1'b0} + {2'b00, matrix_33};
  assign w_ny = {2'b00, matrix_11} + {1'b0, matrix_12, 1'b0} + {2'b00, matrix_13};

  // Compare-and-subtract keeps everything unsigned.
  assign w_gx = (r_px >= r_nx) ? (r_px - r_nx) : (r_nx - r_px);
  assign w_gy = (r_py >= r_ny) ? (r_py - r_ny) : (r_ny - r_py);

  assign w_g = {1'b0, r_gx} + {1'b0, r_gy};

  assign w_col_last = (r_col == H_DISP - 12'd1);
  assign w_row_last = (r_row == V_DISP - 12'd1);

  // Output pixel selection; thresh is sampled here, in stage 3.
  always_comb begin
    w_pix = 8'd0;
    if (OUT_MODE) begin
      w_pix = (w_g > 11'd255) ? 8'd255 : w_g[7:0];
    end else begin
      w_pix = (w_g >= thresh) ? 8'd255 : 8'd0;
    end
  end

  // Valid pipe shifts every clock so input gaps reappear unchanged at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 3'b000;
    end else begin
      r_vld <= {r_vld[1:0], matrix_vld};
    end
  end

  // Stages 1 and 2 datapath registers; they advance every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px <= '0;
      r_nx <= '0;
      r_py <= '0;
      r_ny <= '0;
      r_gx <= '0;
      r_gy <= '0;
    end else begin
      r_px <= w_px;
      r_nx <= w_nx;
      r_py <= w_py;
      r_ny <= w_ny;
      r_gx <= w_gx;
      r_gy <= w_gy;
    end
  end

  // Stage 3: pixel holds when idle; flags are decoded from the counters before they advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 8'd0;
      r_sof  <= 1'b0;
      r_eol  <= 1'b0;
      r_eof  <= 1'b0;
      r_col  <= 12'd0;
      r_row  <= 12'd0;
    end else if (r_vld[1]) begin
      r_dout <= w_pix;
      r_sof  <= (r_col == 12'd0) && (r_row == 12'd0);
      r_eol  <= w_col_last;
      r_eof  <= w_col_last && w_row_last;
      if (w_col_last) begin
        r_col <= 12'd0;
        r_row <= w_row_last ? 12'd0 : r_row + 12'd1;
      end else begin
        r_col <= r_col + 12'd1;
      end
    end else begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
    end
  end

  assign dout_vld = r_vld[2];
  assign dout     = r_dout;
  assign dout_sof = r_sof;
  assign dout_eol = r_eol;
  assign dout_eof = r_eof;

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Bench for sobel_edge_3x3: binary and magnitude instances share one 4x3-frame stimulus stream.
module tb_sobel_edge_3x3;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int FR = H * V;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        matrix_vld;
  logic [7:0]  m11, m12, m13, m21, m22, m23, m31, m32, m33;
  logic [10:0] thresh;

  logic        b_vld, b_sof, b_eol, b_eof;
  logic [7:0]  b_dout;
  logic        g_vld, g_sof, g_eol, g_eof;
  logic [7:0]  g_dout;

  always #5 clk = ~clk;

  sobel_edge_3x3 #(.H_DISP(12'd4), .V_DISP(12'd3), .OUT_MODE(1'b0)) u_bin (
    .clk(clk), .rst_n(rst_n), .matrix_vld(matrix_vld),
    .matrix_11(m11), .matrix_12(m12), .matrix_13(m13),
    .matrix_21(m21), .matrix_22(m22), .matrix_23(m23),
    .matrix_31(m31), .matrix_32(m32), .matrix_33(m33),
    .thresh(thresh), .dout_vld(b_vld), .dout(b_dout),
    .dout_sof(b_sof), .dout_eol(b_eol), .dout_eof(b_eof)
  );

  sobel_edge_3x3 #(.H_DISP(12'd4), .V_DISP(12'd3), .OUT_MODE(1'b1)) u_mag (
    .clk(clk), .rst_n(rst_n), .matrix_vld(matrix_vld),
    .matrix_11(m11), .matrix_12(m12), .matrix_13(m13),
    .matrix_21(m21), .matrix_22(m22), .matrix_23(m23),
    .matrix_31(m31), .matrix_32(m32), .matrix_33(m33),
    .thresh(thresh), .dout_vld(g_vld), .dout(g_dout),
    .dout_sof(g_sof), .dout_eol(g_eol), .dout_eof(g_eof)
  );

  typedef struct {
    logic        vld;
    logic [71:0] win;
    logic [10:0] thr;
    logic [7:0]  eb;   // expected binary pixel
    logic [7:0]  em;   // expected magnitude pixel
  } vec_t;

  vec_t tbl[14];

  int checks   = 0;
  int failures = 0;

  // Expected-value delay line: an entry applied at negedge t is due at negedge t+3.
  logic        p_vld[3];
  logic [7:0]  p_eb[3];
  logic [7:0]  p_em[3];
  logic [10:0] p_thr[3];
  int          n_out;
  logic [7:0]  last_eb, last_em;

  function automatic logic [71:0] mk(input int a11, input int a12, input int a13,
                                     input int a21, input int a22, input int a23,
                                     input int a31, input int a32, input int a33);
    return {8'(a11), 8'(a12), 8'(a13), 8'(a21), 8'(a22), 8'(a23), 8'(a31), 8'(a32), 8'(a33)};
  endfunction

  function automatic logic [7:0] ref_px(input logic [71:0] w, input logic [10:0] thr,
                                        input bit mag);
    int a[9];
    int gx, gy, g;
    for (int i = 0; i < 9; i++) a[i] = int'(w[71-8*i -: 8]);
    gx = (a[2] + 2 * a[5] + a[8]) - (a[0] + 2 * a[3] + a[6]);
    gy = (a[6] + 2 * a[7] + a[8]) - (a[0] + 2 * a[1] + a[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    g = gx + gy;
    if (mag) return (g > 255) ? 8'd255 : 8'(g);
    return (g >= int'(thr)) ? 8'd255 : 8'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin
      p_vld[i] = 1'b0;
      p_eb[i]  = 8'd0;
      p_em[i]  = 8'd0;
      p_thr[i] = 11'd0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin_vld"}, 32'(b_vld), 32'd0);
    chk({tag, "_bin_dout"}, 32'(b_dout), 32'd0);
    chk({tag, "_bin_flags"}, 32'({b_sof, b_eol, b_eof}), 32'd0);
    chk({tag, "_mag_vld"}, 32'(g_vld), 32'd0);
    chk({tag, "_mag_dout"}, 32'(g_dout), 32'd0);
    chk({tag, "_mag_flags"}, 32'({g_sof, g_eol, g_eof}), 32'd0);
  endtask

  task automatic check_out();
    logic sof, eol, eof;
    if (p_vld[2]) begin
      sof = (n_out % FR == 0);
      eol = (n_out % H == H - 1);
      eof = (n_out % FR == FR - 1);
      last_eb = p_eb[2];
      last_em = p_em[2];
      n_out++;
    end else begin
      sof = 1'b0;
      eol = 1'b0;
      eof = 1'b0;
    end
    chk("bin_vld", 32'(b_vld), 32'(p_vld[2]));
    chk("mag_vld", 32'(g_vld), 32'(p_vld[2]));
    chk("bin_dout", 32'(b_dout), 32'(last_eb));
    chk("mag_dout", 32'(g_dout), 32'(last_em));
    chk("bin_sof_eol_eof", 32'({b_sof, b_eol, b_eof}), 32'({sof, eol, eof}));
    chk("mag_sof_eol_eof", 32'({g_sof, g_eol, g_eof}), 32'({sof, eol, eof}));
  endtask

  // One clock: check the output due now, push a new entry, drive inputs.
  task automatic step(input logic vld, input logic [71:0] win, input logic [10:0] thr,
                      input logic [7:0] eb, input logic [7:0] em);
    @(negedge clk);
    check_out();
    for (int i = 2; i > 0; i--) begin
      p_vld[i] = p_vld[i-1];
      p_eb[i]  = p_eb[i-1];
      p_em[i]  = p_em[i-1];
      p_thr[i] = p_thr[i-1];
    end
    p_vld[0] = vld;
    p_eb[0]  = eb;
    p_em[0]  = em;
    p_thr[0] = thr;
    // The window entering stage 3 at the next edge was applied two clocks ago.
    thresh = p_thr[2];
    matrix_vld = vld;
    {m11, m12, m13, m21, m22, m23, m31, m32, m33} = win;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 72'd0, 11'd0, 8'd0, 8'd0);
  endtask

  task automatic rand_win(input logic [10:0] thr);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    step(1'b1, r[71:0], thr, ref_px(r[71:0], thr, 1'b0), ref_px(r[71:0], thr, 1'b1));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    matrix_vld = 1'b1;   // windows offered during reset must be dropped
    clear_pipe();
    n_out = 0;
    last_eb = 8'd0;
    last_em = 8'd0;
    #1 chk_zero("rst_async");
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    rst_n = 1'b1;
    matrix_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    matrix_vld = 1'b0;
    {m11, m12, m13, m21, m22, m23, m31, m32, m33} = 72'd0;
    thresh = 11'd0;
    clear_pipe();
    n_out = 0;
    last_eb = 8'd0;
    last_em = 8'd0;

    tbl[0]  = '{1'b1, mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 11'd1,    8'd0,   8'd0};
    tbl[1]  = '{1'b1, mk(0, 255, 255, 0, 255, 255, 0, 255, 255),       11'd500,  8'd255, 8'd255};
    tbl[2]  = '{1'b1, mk(0, 0, 10, 0, 0, 10, 0, 0, 10),                11'd40,   8'd255, 8'd40};
    tbl[3]  = '{1'b1, mk(0, 0, 10, 0, 0, 10, 0, 0, 10),                11'd41,   8'd0,   8'd40};
    tbl[4]  = '{1'b0, 72'd0,                                           11'd0,    8'd0,   8'd0};
    tbl[5]  = '{1'b1, mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 11'd0,    8'd255, 8'd0};
    tbl[6]  = '{1'b1, mk(0, 0, 0, 200, 200, 200, 200, 200, 200),       11'd800,  8'd255, 8'd255};
    tbl[7]  = '{1'b1, mk(50, 0, 0, 0, 0, 0, 0, 0, 0),                  11'd101,  8'd0,   8'd100};
    tbl[8]  = '{1'b0, 72'd0,                                           11'd0,    8'd0,   8'd0};
    tbl[9]  = '{1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 255),                 11'd2040, 8'd0,   8'd255};
    tbl[10] = '{1'b1, mk(0, 0, 0, 0, 0, 60, 0, 0, 0),                  11'd120,  8'd255, 8'd120};
    tbl[11] = '{1'b1, mk(0, 70, 0, 0, 0, 0, 0, 0, 0),                  11'd200,  8'd0,   8'd140};
    tbl[12] = '{1'b1, mk(10, 20, 30, 40, 50, 60, 70, 80, 90),          11'd320,  8'd255, 8'd255};
    tbl[13] = '{1'b1, mk(0, 0, 0, 100, 0, 0, 0, 0, 0),                 11'd1,    8'd255, 8'd200};

    // Reset state.
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Directed gradient vectors, mostly back-to-back with a couple of gaps.
    for (int i = 0; i < 14; i++) step(tbl[i].vld, tbl[i].win, tbl[i].thr, tbl[i].eb, tbl[i].em);
    idle(4);

    // Back-to-back distinct gradients against the reference model.
    for (int i = 0; i < 16; i++) rand_win(11'd300);
    idle(4);

    // Framing on a fresh 4x3 frame with random gaps, then the start of the next frame.
    do_reset(2);
    for (int i = 0; i < FR; i++) begin
      rand_win(11'(200 + i * 40));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    for (int i = 0; i < 4; i++) rand_win(11'd250);
    idle(4);
    chk("frame_output_count", 32'(n_out), 32'(FR + 4));

    // Reset midway through line 2, then a full frame.
    do_reset(2);
    for (int i = 0; i < 7; i++) rand_win(11'd400);
    do_reset(2);
    for (int i = 0; i < FR; i++) rand_win(11'd150);
    idle(4);
    chk("post_reset_output_count", 32'(n_out), 32'(FR));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_edge_3x3.md
Name: sobel_edge_3x3

Overview:
- Consumes the 3x3 neighbourhood stream produced by the line-buffer window generator.
- Computes the Sobel gradient magnitude approximation |Gx|+|Gy| and emits one 8-bit edge pixel per valid window.
- Output is either a binary edge map or a saturated magnitude.
- Regenerates frame/line framing flags on the output stream for the downstream display/write-back path.

Parameters:
- H_DISP, 12'd640, image width in pixels (windows per line)
- V_DISP, 12'd480, image height in lines
- OUT_MODE, 1'b0, 0 = binary (255/0 against thresh), 1 = magnitude saturated to 255

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- matrix_vld  input  1  window valid; asserted one cycle after the window generator's din_vld
- matrix_11..matrix_33  input  8 each  window pixels, row-major (11 = top-left, 33 = bottom-right)
- thresh  input  11  edge threshold, used only in binary mode
- dout_vld  output  1  output pixel valid
- dout  output  8  edge pixel
- dout_sof  output  1  high with first pixel of frame (row 0, col 0)
- dout_eol  output  1  high with last pixel of each line
- dout_eof  output  1  high with last pixel of frame

Behaviour:
- Reset state is set by rst_n, which is asynchronous and active-low; clock is clk.
- In reset, all pipeline registers, counters, dout_vld, dout, dout_sof, dout_eol and dout_eof are 0.
- Fixed 3-stage pipeline with no stall and no backpressure. Stages advance every clk.
- matrix_vld shifts through a 3-bit valid pipe. dout_vld equals matrix_vld delayed 3 cycles.
- Gaps in matrix_vld appear unchanged as gaps in dout_vld.
- Stage 1 registers four 10-bit unsigned partial sums:
  - Px = m13 + 2*m23 + m33
  - Nx = m11 + 2*m21 + m31
  - Py = m31 + 2*m32 + m33
  - Ny = m11 + 2*m12 + m13
  - Each sum has maximum value 1020.
- Stage 2 registers |Gx| = |Px - Nx| and |Gy| = |Py - Ny|, each 10 bits unsigned. Compare-and-subtract is used, so there is no signed overflow.
- Stage 3 computes G = |Gx| + |Gy|, 11 bits, maximum 2040, then:
  - OUT_MODE=0: dout = (G >= thresh) ? 8'd255 : 8'd0. thresh is sampled in stage 3. thresh = 0 gives an all-255 output.
  - OUT_MODE=1: dout = (G > 255) ? 8'd255 : G[7:0].
- dout holds its last value while dout_vld = 0.
- Output framing counters:
  - out_col (12 bit) increments on dout_vld and wraps to 0 at H_DISP-1.
  - out_row (12 bit) increments on the out_col wrap and wraps to 0 at V_DISP-1.
  - Both counters are registered alongside stage 3, so the flags align with dout.
  - dout_sof = dout_vld && out_col==0 && out_row==0.
  - dout_eol = dout_vld && out_col==H_DISP-1.
  - dout_eof = dout_eol && out_row==V_DISP-1.
  - The frame after the last one starts again at row 0, col 0 with no idle cycles required.
- Border handling is inherited from the upstream pixel replication. This block applies no special border logic and produces exactly H_DISP*V_DISP valid outputs per frame.
- Reset mid-frame: the pipeline and counters clear immediately. Any window in flight is dropped with no dout_vld. The first valid window after rst_n deasserts is treated as row 0, col 0.
- If matrix_vld is asserted while dout_vld is high, the in-flight result is unaffected. Throughput is 1 pixel per clock.

Test Plan:
- Flat field, all taps = 100, thresh = 1, OUT_MODE=0 -> G=0, dout=0 exactly 3 cycles after each matrix_vld.
- Vertical edge, left column 0 and middle/right columns 255 -> Gx=1020, Gy=0, G=1020:
  - OUT_MODE=0, thresh=500 -> dout=255.
  - OUT_MODE=1 -> dout=255 (saturated).
- Right column = 10, others 0 -> G=40:
  - thresh=40 -> dout=255; thresh=41 -> dout=0.
  - OUT_MODE=1 -> dout=40.
- H_DISP=4, V_DISP=3, 12 windows with random matrix_vld gaps:
  - dout_sof on output 1 only.
  - dout_eol on outputs 4, 8 and 12.
  - dout_eof on output 12 only.
  - Next frame's output 1 raises dout_sof again.
- Back-to-back valid windows, each with a distinct gradient -> each dout matches the reference model in order at 1 per cycle with latency 3.
- Assert rst_n low for 2 cycles midway through line 2, then restart a frame -> no spurious dout_vld from dropped windows. The first post-reset output carries dout_sof=1, and outputs are all 0 during reset.
